// File: rtl/ram_stream_reader.sv
// Streams len_i consecutive RAM words from base_addr_i as valid/ready beats through a 4-word buffer.
// Optional RAM_READER_LOOP_EN adds loop_i: the pass repeats until abort_i or rst_i.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
`ifdef RAM_READER_LOOP_EN
    input  logic                  loop_i,
`endif
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

    state_t              state, state_d;
    logic                done_d;
    logic                start_ok;
    logic [ADDR_WIDTH:0] rem;
    logic                issue_last;
    logic                loop_r;
    logic                vld_p0;
    logic                last_p0;

    logic [DATA_WIDTH:0] q_mem [0:3];
    logic [1:0]          q_wr_ptr, q_rd_ptr;
    logic [2:0]          q_count;
    logic [2:0]          occ;
    logic                room, flush, pop, out_free, q_pop, q_push, direct, wr_en;

`ifdef RAM_READER_LOOP_EN
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH:0]   len_r;
`else
    assign loop_r = 1'b0;
`endif

    assign start_ok   = (state == IDLE) && start_i && !abort_i;
    assign issue_last = (rem == {{ADDR_WIDTH{1'b0}}, 1'b1});
    assign busy_o     = (state != IDLE);
    assign flush      = abort_i && (state != IDLE);
    assign pop        = valid_o && ready_i;
    assign out_free   = !valid_o || pop;
    // Words landing while flushing belong to the aborted transfer and are dropped.
    assign wr_en      = vld_p0 && (state != FLUSH) && !flush;
    assign q_pop      = out_free && (q_count != 3'd0);
    assign direct     = out_free && (q_count == 3'd0) && wr_en;
    assign q_push     = wr_en && !direct;
    // Output register plus queue hold 4 words; a read is only issued if its word has a slot.
    assign occ        = q_count + {2'b00, valid_o};
    assign room       = (occ + {2'b00, vld_p0}) <= 3'd3;

    always_comb begin
        state_d = state;
        rd_o    = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (len_i != '0) state_d = ISSUE;
                    else             done_d  = 1'b1;
                end
            end
            ISSUE: begin
                rd_o = room;
                if (abort_i)                            state_d = FLUSH;
                else if (room && issue_last && !loop_r) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort_i) state_d = FLUSH;
                else if (pop && last_o) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            FLUSH: begin
                // The only possible in-flight read lands during this cycle and is discarded.
                state_d = abort_i ? FLUSH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: read issued, RAM word arrives on rd_data_i next cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            done_o    <= 1'b0;
            rem       <= '0;
            rd_addr_o <= '0;
            vld_p0    <= 1'b0;
            last_p0   <= 1'b0;
`ifdef RAM_READER_LOOP_EN
            loop_r    <= 1'b0;
            base_r    <= '0;
            len_r     <= '0;
`endif
        end else begin
            state   <= state_d;
            done_o  <= done_d;
            vld_p0  <= rd_o;
            last_p0 <= rd_o && issue_last;
            if (start_ok) begin
                rem       <= len_i;
                rd_addr_o <= base_addr_i;
`ifdef RAM_READER_LOOP_EN
                loop_r    <= loop_i;
                base_r    <= base_addr_i;
                len_r     <= len_i;
`endif
            end else if (rd_o) begin
                rd_addr_o <= rd_addr_o + 1'b1;
                rem       <= rem - 1'b1;
`ifdef RAM_READER_LOOP_EN
                if (issue_last && loop_r) begin
                    rd_addr_o <= base_r;
                    rem       <= len_r;
                end
`endif
            end
        end
    end

    // Stage p1: RAM word captured into output register or queue
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_count  <= 3'd0;
            q_wr_ptr <= 2'd0;
            q_rd_ptr <= 2'd0;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            data_o   <= '0;
        end else if (flush) begin
            q_count  <= 3'd0;
            q_wr_ptr <= 2'd0;
            q_rd_ptr <= 2'd0;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
        end else begin
            if (q_push) q_wr_ptr <= q_wr_ptr + 1'b1;
            if (q_pop)  q_rd_ptr <= q_rd_ptr + 1'b1;
            q_count <= q_count + {2'b00, q_push} - {2'b00, q_pop};
            if (q_pop) begin
                {last_o, data_o} <= q_mem[q_rd_ptr];
                valid_o          <= 1'b1;
            end else if (direct) begin
                last_o  <= last_p0;
                data_o  <= rd_data_i;
                valid_o <= 1'b1;
            end else if (pop) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (q_push) q_mem[q_wr_ptr] <= {last_p0, rd_data_i};
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle registered RAM model preloaded addr=data.
// Define RAM_READER_LOOP_EN for both files to exercise the looping build.
module tb_ram_stream_reader;
    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_i, start_i, abort_i, ready_i;
    logic [AW-1:0] base_addr_i;
    logic [AW:0]   len_i;
`ifdef RAM_READER_LOOP_EN
    logic          loop_i;
`endif
    logic          busy_o, done_o, rd_o, valid_o, last_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_i, data_o;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [DW-1:0] got_data [0:31];
    logic          got_last [0:31];
    logic [AW-1:0] got_addr [0:31];
    int got_n, rd_cnt, done_cnt, done_iter, last_hs_iter, max_out, stall_bad;
    logic busy_at_done;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
`ifdef RAM_READER_LOOP_EN
        .loop_i      (loop_i),
`endif
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_addr_o   (rd_addr_o),
        .rd_o        (rd_o),
        .rd_data_i   (rd_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_o) rd_data_i <= ram[rd_addr_o];

    // Runs ncyc cycles after a start has been set up, recording handshaken words and issued reads.
    task automatic collect(input int ncyc, input logic [31:0] pat, input int inj);
        logic pv, pr, pl, prd;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        got_n = 0; rd_cnt = 0; done_cnt = 0; done_iter = -1; last_hs_iter = -1;
        max_out = 0; stall_bad = 0; busy_at_done = 1'b1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; prd = 1'b0; pd = '0; pa = '0;
        for (int i = 0; i < 32; i++) begin got_data[i] = 'x; got_last[i] = 1'bx; end
        for (int j = 1; j <= ncyc; j++) begin
            @(posedge clk); #1;
            start_i = (j == inj);
            if (j == inj) begin base_addr_i = 5'd20; len_i = 6'd7; end
            if (pv && pr) begin
                if (got_n < 32) begin got_data[got_n] = pd; got_last[got_n] = pl; end
                got_n++;
                if (pl) last_hs_iter = j;
            end
            if (prd) begin
                if (rd_cnt < 32) got_addr[rd_cnt] = pa;
                rd_cnt++;
            end
            if (rd_cnt - got_n > max_out) max_out = rd_cnt - got_n;
            if (pv && !pr && (!valid_o || data_o !== pd || last_o !== pl)) stall_bad++;
            if (done_o) begin done_cnt++; done_iter = j; busy_at_done = busy_o; end
            pv = valid_o; pd = data_o; pl = last_o; prd = rd_o; pa = rd_addr_o;
            pr = pat[j % 32];
            ready_i = pr;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
        base_addr_i = '0; len_i = '0;
`ifdef RAM_READER_LOOP_EN
        loop_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if ({busy_o, done_o, rd_o, valid_o, last_o} !== 5'b0) begin
            miss_cnt++; $display("FAIL reset_ctrl: got %b expected 00000", {busy_o, done_o, rd_o, valid_o, last_o}); end
        vec_cnt++; if (rd_addr_o !== 5'd0 || data_o !== 8'd0) begin
            miss_cnt++; $display("FAIL reset_data: got addr %0d data %0h expected 0 0", rd_addr_o, data_o); end
        rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic ev, el, ed, eb, er;
        start_i = 1'b1; base_addr_i = 5'd3; len_i = 6'd5; ready_i = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            ev = (k >= 3 && k <= 7); el = (k == 7); ed = (k == 8); eb = (k <= 7); er = (k <= 5);
            vec_cnt++; if (valid_o !== ev) begin
                miss_cnt++; $display("FAIL basic_valid c%0d: got %b expected %b", k, valid_o, ev); end
            if (ev) begin
                vec_cnt++; if (data_o !== 8'(k)) begin
                    miss_cnt++; $display("FAIL basic_data c%0d: got %0d expected %0d", k, data_o, k); end
            end
            vec_cnt++; if ((valid_o && last_o) !== el) begin
                miss_cnt++; $display("FAIL basic_last c%0d: got %b expected %b", k, valid_o && last_o, el); end
            vec_cnt++; if (done_o !== ed) begin
                miss_cnt++; $display("FAIL basic_done c%0d: got %b expected %b", k, done_o, ed); end
            vec_cnt++; if (busy_o !== eb) begin
                miss_cnt++; $display("FAIL basic_busy c%0d: got %b expected %b", k, busy_o, eb); end
            vec_cnt++; if (rd_o !== er) begin
                miss_cnt++; $display("FAIL basic_rd c%0d: got %b expected %b", k, rd_o, er); end
            if (er) begin
                vec_cnt++; if (rd_addr_o !== 5'(k + 2)) begin
                    miss_cnt++; $display("FAIL basic_addr c%0d: got %0d expected %0d", k, rd_addr_o, k + 2); end
            end
        end
        ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        int exp_a [0:3];
        exp_a = '{30, 31, 0, 1};
        start_i = 1'b1; base_addr_i = 5'd30; len_i = 6'd4; ready_i = 1'b1;
        collect(12, 32'hFFFF_FFFF, 0);
        vec_cnt++; if (rd_cnt !== 4 || got_n !== 4) begin
            miss_cnt++; $display("FAIL wrap_count: got reads %0d words %0d expected 4 4", rd_cnt, got_n); end
        for (int i = 0; i < 4; i++) begin
            vec_cnt++; if (got_addr[i] !== 5'(exp_a[i]) || got_data[i] !== 8'(exp_a[i]) || got_last[i] !== (i == 3)) begin
                miss_cnt++; $display("FAIL wrap_word%0d: got addr %0d data %0d last %b expected %0d %0d %b",
                                     i, got_addr[i], got_data[i], got_last[i], exp_a[i], exp_a[i], i == 3); end
        end
        vec_cnt++; if (done_cnt !== 1 || done_iter !== last_hs_iter || busy_at_done !== 1'b0) begin
            miss_cnt++; $display("FAIL wrap_done: got count %0d at %0d busy %b expected 1 at %0d busy 0",
                                 done_cnt, done_iter, busy_at_done, last_hs_iter); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pats [0:1];
        pats = '{32'hB26D_1CA7, 32'hFFFF_F000};
        for (int p = 0; p < 2; p++) begin
            start_i = 1'b1; base_addr_i = 5'd10; len_i = 6'd8; ready_i = 1'b0;
            collect(40, pats[p], 0);
            vec_cnt++; if (got_n !== 8 || rd_cnt !== 8) begin
                miss_cnt++; $display("FAIL bp%0d_count: got words %0d reads %0d expected 8 8", p, got_n, rd_cnt); end
            for (int i = 0; i < 8; i++) begin
                vec_cnt++; if (got_data[i] !== 8'(10 + i) || got_last[i] !== (i == 7)) begin
                    miss_cnt++; $display("FAIL bp%0d_word%0d: got %0d last %b expected %0d last %b",
                                         p, i, got_data[i], got_last[i], 10 + i, i == 7); end
            end
            vec_cnt++; if (stall_bad !== 0) begin
                miss_cnt++; $display("FAIL bp%0d_stable: got %0d unstable stalls expected 0", p, stall_bad); end
            vec_cnt++; if (p == 0 ? (max_out > 4) : (max_out !== 4)) begin
                miss_cnt++; $display("FAIL bp%0d_outstanding: got %0d expected %s4", p, max_out, p == 0 ? "<=" : ""); end
            vec_cnt++; if (done_cnt !== 1 || done_iter !== last_hs_iter) begin
                miss_cnt++; $display("FAIL bp%0d_done: got count %0d at %0d expected 1 at %0d",
                                     p, done_cnt, done_iter, last_hs_iter); end
        end
    endtask

    task automatic test_len0_and_busy_start();
        start_i = 1'b1; base_addr_i = 5'd9; len_i = 6'd0; ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        vec_cnt++; if ({done_o, busy_o, rd_o} !== 3'b100) begin
            miss_cnt++; $display("FAIL len0_pulse: got done/busy/rd %b expected 100", {done_o, busy_o, rd_o}); end
        @(posedge clk); #1;
        vec_cnt++; if ({done_o, busy_o, rd_o, valid_o} !== 4'b0000) begin
            miss_cnt++; $display("FAIL len0_after: got done/busy/rd/valid %b expected 0000", {done_o, busy_o, rd_o, valid_o}); end
        start_i = 1'b1; base_addr_i = 5'd5; len_i = 6'd3;
        collect(12, 32'hFFFF_FFFF, 2);
        vec_cnt++; if (got_n !== 3 || rd_cnt !== 3) begin
            miss_cnt++; $display("FAIL busy_start_count: got words %0d reads %0d expected 3 3", got_n, rd_cnt); end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (got_data[i] !== 8'(5 + i) || got_addr[i] !== 5'(5 + i) || got_last[i] !== (i == 2)) begin
                miss_cnt++; $display("FAIL busy_start_word%0d: got data %0d addr %0d last %b expected %0d %0d %b",
                                     i, got_data[i], got_addr[i], got_last[i], 5 + i, 5 + i, i == 2); end
        end
        vec_cnt++; if (done_cnt !== 1 || busy_o !== 1'b0) begin
            miss_cnt++; $display("FAIL busy_start_end: got done count %0d busy %b expected 1 0", done_cnt, busy_o); end
    endtask

    task automatic test_abort();
        int done_seen;
        logic idle_by3;
        start_i = 1'b1; base_addr_i = 5'd0; len_i = 6'd10; ready_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (k == 5) ready_i = 1'b0;
        end
        vec_cnt++; if (valid_o !== 1'b1 || data_o !== 8'd2) begin
            miss_cnt++; $display("FAIL abort_pre: got valid %b data %0d expected 1 2", valid_o, data_o); end
        @(posedge clk); #1;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        vec_cnt++; if ({valid_o, last_o, rd_o} !== 3'b000) begin
            miss_cnt++; $display("FAIL abort_next: got valid/last/rd %b expected 000", {valid_o, last_o, rd_o}); end
        done_seen = (done_o === 1'b1) ? 1 : 0;
        idle_by3 = !busy_o;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) done_seen++;
            if (busy_o === 1'b0) idle_by3 = 1'b1;
        end
        vec_cnt++; if (done_seen !== 0) begin
            miss_cnt++; $display("FAIL abort_done: got %0d done pulses expected 0", done_seen); end
        vec_cnt++; if (idle_by3 !== 1'b1 || valid_o !== 1'b0) begin
            miss_cnt++; $display("FAIL abort_idle: got idle %b valid %b expected 1 0", idle_by3, valid_o); end
        start_i = 1'b1; base_addr_i = 5'd12; len_i = 6'd2; ready_i = 1'b1;
        collect(10, 32'hFFFF_FFFF, 0);
        vec_cnt++; if (got_n !== 2 || got_data[0] !== 8'd12 || got_data[1] !== 8'd13 || got_last[1] !== 1'b1 || done_cnt !== 1) begin
            miss_cnt++; $display("FAIL abort_restart: got n %0d data %0d,%0d last %b done %0d expected 2 12,13 1 1",
                                 got_n, got_data[0], got_data[1], got_last[1], done_cnt); end
    endtask

    task automatic test_mid_reset();
        start_i = 1'b1; base_addr_i = 5'd4; len_i = 6'd10; ready_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (valid_o !== 1'b1 || data_o !== 8'd4) begin
            miss_cnt++; $display("FAIL midrst_pre: got valid %b data %0d expected 1 4", valid_o, data_o); end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        vec_cnt++; if ({busy_o, done_o, rd_o, valid_o, last_o} !== 5'b0 || data_o !== 8'd0 || rd_addr_o !== 5'd0) begin
            miss_cnt++; $display("FAIL midrst_state: got ctrl %b data %0d addr %0d expected 00000 0 0",
                                 {busy_o, done_o, rd_o, valid_o, last_o}, data_o, rd_addr_o); end
        @(posedge clk); #1;
        vec_cnt++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            miss_cnt++; $display("FAIL midrst_quiet: got valid %b busy %b expected 0 0", valid_o, busy_o); end
        start_i = 1'b1; base_addr_i = 5'd8; len_i = 6'd1; ready_i = 1'b1;
        collect(8, 32'hFFFF_FFFF, 0);
        vec_cnt++; if (got_n !== 1 || got_data[0] !== 8'd8 || got_last[0] !== 1'b1 || done_cnt !== 1) begin
            miss_cnt++; $display("FAIL midrst_restart: got n %0d data %0d last %b done %0d expected 1 8 1 1",
                                 got_n, got_data[0], got_last[0], done_cnt); end
    endtask

`ifdef RAM_READER_LOOP_EN
    task automatic test_loop();
        loop_i = 1'b1; start_i = 1'b1; base_addr_i = 5'd0; len_i = 6'd3; ready_i = 1'b1;
        collect(14, 32'hFFFF_FFFF, 0);
        loop_i = 1'b0;
        vec_cnt++; if (got_n < 9 || done_cnt !== 0 || busy_o !== 1'b1) begin
            miss_cnt++; $display("FAIL loop_run: got words %0d done %0d busy %b expected >=9 0 1", got_n, done_cnt, busy_o); end
        for (int i = 0; i < 9; i++) begin
            vec_cnt++; if (got_data[i] !== 8'(i % 3) || got_last[i] !== (i % 3 == 2)) begin
                miss_cnt++; $display("FAIL loop_word%0d: got %0d last %b expected %0d last %b",
                                     i, got_data[i], got_last[i], i % 3, i % 3 == 2); end
        end
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        vec_cnt++; if (valid_o !== 1'b0 || rd_o !== 1'b0) begin
            miss_cnt++; $display("FAIL loop_abort: got valid %b rd %b expected 0 0", valid_o, rd_o); end
        @(posedge clk); #1;
        vec_cnt++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            miss_cnt++; $display("FAIL loop_idle: got busy %b done %b expected 0 0", busy_o, done_o); end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'(i);
        test_reset();
        test_basic();
        repeat (2) @(posedge clk);
        #1;
        test_wrap();
        test_backpressure();
        test_len0_and_busy_start();
        test_abort();
        test_mid_reset();
`ifdef RAM_READER_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
